// File: rtl/dmem_store_buffer.sv
// -----------------------------------------------------------------------------
// dmem_store_buffer
// Posted-write store buffer between the core data-memory port and external
// data memory. Core stores land in a DEPTH-entry FIFO in one cycle and are
// drained to memory over a req/ack write port. Core loads read memory
// combinationally; a load that hits a buffered store either stalls until the
// matching entries drain (default build) or is forwarded from the youngest
// matching entry (SB_FORWARD_EN defined).
//
// Compile-time option: SB_FORWARD_EN -- enables store-to-load forwarding.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   st_valid   core store this cycle      ld_valid  core load this cycle
//   addr       core data address          wdata     core store data
//   rdata      load data to core          stall     core must hold this cycle
//   mem_raddr  memory read address (=addr) mem_rdata memory read data
//   mem_wreq   write request              mem_wack  write accepted at this edge
//   mem_waddr  head entry address         mem_wdata head entry data
//   count      occupied entries           empty     count==0
// -----------------------------------------------------------------------------
module dmem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    input  logic                   ld_valid,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   stall,
    output logic [31:0]            mem_raddr,
    input  logic [31:0]            mem_rdata,
    output logic                   mem_wreq,
    output logic [31:0]            mem_waddr,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_wack,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] r_count;
    logic [PW-1:0] w_count_next;
    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_pop;
    logic          w_match;
    logic          w_hit;
`ifdef SB_FORWARD_EN
    logic [31:0]   w_fwd_data;
`endif

    // Word-granular address compare; byte offset is ignored.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    assign w_empty = (r_head == r_tail);
    // Pointers carry one extra wrap bit: same index with differing wrap bit is full.
    assign w_full  = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);
    // Full blocks enqueue even when a pop happens at the same edge.
    assign w_enq   = st_valid & ~w_full;
    assign w_pop   = (r_state == ST_REQ) & mem_wack;

    // Occupancy after the coming edge.
    always_comb begin
        w_count_next = r_count;
        case ({w_enq, w_pop})
            2'b10:   w_count_next = r_count + PW'(1);
            2'b01:   w_count_next = r_count - PW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Write-port next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // A store landing this edge also starts the request, so a
                // stream of stores with mem_wack held high drains one per cycle.
                if (!w_empty || w_enq) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (w_pop && (w_count_next == {PW{1'b0}})) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {PW{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
        end
    end

    // Entry storage; cleared on reset so the write port shows zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= 32'h0000_0000;
                r_data[i] <= 32'h0000_0000;
            end
        end else if (w_enq) begin
            r_addr[r_tail[AW-1:0]] <= addr;
            r_data[r_tail[AW-1:0]] <= wdata;
        end
    end

    // Scan occupied entries oldest to youngest; the last match wins.
    always_comb begin
        w_match = 1'b0;
`ifdef SB_FORWARD_EN
        w_fwd_data = 32'h0000_0000;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if ((PW'(k) < r_count) && word_match(r_addr[r_head[AW-1:0] + AW'(k)], addr)) begin
                w_match = 1'b1;
`ifdef SB_FORWARD_EN
                w_fwd_data = r_data[r_head[AW-1:0] + AW'(k)];
`endif
            end else begin
                w_match = w_match;
            end
        end
    end

    assign w_hit = ld_valid & w_match;

`ifdef SB_FORWARD_EN
    assign stall = st_valid & w_full;
    assign rdata = w_hit ? w_fwd_data : mem_rdata;
`else
    // A load alongside a store is treated as the store only.
    assign stall = (st_valid & w_full) | (ld_valid & ~st_valid & w_hit);
    assign rdata = mem_rdata;
`endif

    assign mem_raddr = addr;
    assign mem_wreq  = (r_state == ST_REQ);
    assign mem_waddr = r_addr[r_head[AW-1:0]];
    assign mem_wdata = r_data[r_head[AW-1:0]];
    assign count     = r_count;
    assign empty     = w_empty;

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;
`ifdef SB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, ld_valid, mem_wack;
    logic [31:0] addr, wdata, mem_rdata;
    logic [31:0] rdata, mem_raddr, mem_waddr, mem_wdata;
    logic        stall, mem_wreq, empty;
    logic [$clog2(DEPTH):0] count;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t model_q[$];   // reference buffer contents, oldest first
    ent_t exp_q[$];     // scoreboard of writes expected on the memory port
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .ld_valid(ld_valid),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wreq(mem_wreq),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wack(mem_wack),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest buffered store to the same word, if any.
    function automatic bit model_hit(input logic [31:0] a, output logic [31:0] d);
        bit h;
        h = 1'b0;
        d = 32'h0;
        foreach (model_q[i]) begin
            if (model_q[i].a[31:2] == a[31:2]) begin
                h = 1'b1;
                d = model_q[i].d;
            end
        end
        return h;
    endfunction

    // Reference behaviour at a clock edge: pop if a write is outstanding and
    // acked, enqueue if the store found room before the edge.
    task automatic model_edge();
        bit   do_pop, do_enq;
        ent_t e;
        do_pop = (model_q.size() != 0) && mem_wack;
        do_enq = st_valid && (model_q.size() < DEPTH);
        if (do_pop) void'(model_q.pop_front());
        if (do_enq) begin
            e.a = addr;
            e.d = wdata;
            model_q.push_back(e);
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input bit st, input bit ld, input logic [31:0] a, input logic [31:0] d,
                        input bit wk, input logic [31:0] rd);
        st_valid  = st;
        ld_valid  = ld;
        addr      = a;
        wdata     = d;
        mem_wack  = wk;
        mem_rdata = rd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: compare DUT outputs to the reference each cycle, and pop the
    // scoreboard whenever the memory accepts a write.
    always @(negedge clk) begin
        logic [31:0] fd;
        bit          h;
        bit          exp_stall;
        logic [31:0] exp_rdata;
        ent_t        e;
        h         = ld_valid && model_hit(addr, fd);
        exp_stall = (st_valid && model_q.size() == DEPTH) || (ld_valid && !st_valid && h && !FWD);
        exp_rdata = (FWD && h) ? fd : mem_rdata;
        chk("count", 32'(count), 32'(model_q.size()));
        chk("empty", 32'(empty), 32'(model_q.size() == 0));
        chk("mem_wreq", 32'(mem_wreq), 32'(model_q.size() != 0));
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("rdata", rdata, exp_rdata);
        chk("mem_raddr", mem_raddr, addr);
        if (mem_wreq) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wreq", 32'(mem_wreq), 32'h0);
            end else begin
                chk("waddr", mem_waddr, exp_q[0].a);
                chk("wdata", mem_wdata, exp_q[0].d);
                if (mem_wack) void'(exp_q.pop_front());
            end
        end
    end

    logic [31:0] pool [4];

    initial begin
        pool[0] = 32'h0000_0200;
        pool[1] = 32'h0000_0300;
        pool[2] = 32'h0000_0600;
        pool[3] = 32'h0000_0604;
        st_valid = 1'b0; ld_valid = 1'b0; mem_wack = 1'b0;
        addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h1234_5678;
        reset = 1'b1;
        #1 reset = 1'b0;
        #12;
        chk("rst_waddr", mem_waddr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", rdata, 32'h1234_5678);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single store, held off, then acked.
        step(1'b1, 1'b0, 32'h0000_0100, 32'hAAAA_0001, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Fill the buffer; the 5th store stalls until a pop frees a slot.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0000_0410, 32'hB000_0004, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0000_0410, 32'hB000_0004, 1'b1, 32'h0);
        step(1'b1, 1'b0, 32'h0000_0410, 32'hB000_0004, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

        // Two stores to the same word, then loads of that word and of another.
        step(1'b1, 1'b0, 32'h0000_0200, 32'h0000_0011, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0000_0200, 32'h0000_0022, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0200, 32'h0, 1'b0, 32'h0000_DEAD);
        step(1'b0, 1'b1, 32'h0000_0202, 32'h0, 1'b0, 32'h0000_DEAD);
        step(1'b0, 1'b1, 32'h0000_0300, 32'h0, 1'b0, 32'h0000_BEEF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h0000_0200, 32'h0, 1'b1, 32'h0000_DEAD);

        // Store every cycle with mem_wack held high; wraps the pointers.
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 32'h500 + 32'(4 * i), $urandom, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

        // Randomized traffic over a small address pool to provoke hits.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 2) == 0), $urandom);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

        // Reset in the middle of a drain with three stores pending.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 32'h700 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 32'h0);
        st_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'h0);
        chk("midrst_empty", 32'(empty), 32'h1);
        chk("midrst_wreq", 32'(mem_wreq), 32'h0);
        model_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write store buffer between the single-cycle core's data-memory port and the external data memory. Core stores (MemWrite, ALUResult address, WriteData) are captured into a DEPTH-entry FIFO in one cycle and drained to memory over a req/ack write port, so slow memory writes do not stall the core until the buffer fills. Core loads read memory combinationally. With forwarding compiled in, loads that hit a buffered store are serviced from the buffer; without it, they stall until that store drains.

## Interface
- DEPTH, 4, number of buffer entries; power of two, ≥2
- clk  in  1  rising-edge clock (the only clock)
- reset  in  1  asynchronous, active-low; 0 clears the block immediately
- st_valid  in  1  core store this cycle (MemWrite)
- ld_valid  in  1  core load this cycle
- addr  in  32  core data address (ALUResult)
- wdata  in  32  core store data (WriteData)
- rdata  out  32  load data to core (ReadData)
- stall  out  1  core must hold PC and instruction this cycle
- mem_raddr  out  32  memory read address, always equal to addr
- mem_rdata  in  32  combinational memory read data
- mem_wreq  out  1  write request to memory
- mem_waddr  out  32  write address of head entry
- mem_wdata  out  32  write data of head entry
- mem_wack  in  1  memory accepts write at this edge when mem_wreq=1
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count==0

## Operation
- Stores are full-word. Address matching uses addr[31:2]. addr[1:0] is stored but ignored for matching.
- The FIFO uses head/tail pointers of $clog2(DEPTH)+1 bits, wrapping modulo 2·DEPTH.
  - full when the pointers differ only in the MSB.
  - empty when they are equal.
- Enqueue at an edge when st_valid=1 and !full.
- full blocks enqueue even if mem_wack pops in the same cycle (no fall-through).
- If st_valid and ld_valid are both 1, the cycle is treated as a store only.
- Write-port FSM:
  - IDLE: mem_wreq=0; if !empty → REQ.
  - REQ: mem_wreq=1. On mem_wack, pop head; stay in REQ if entries remain after the pop (back-to-back), else → IDLE.
- mem_waddr/mem_wdata are driven from the head entry and stay stable while mem_wreq=1.
- Hit: ld_valid=1 and any occupied entry, including the head entry in flight, matches addr[31:2].
- rdata = mem_rdata on a miss. On a hit, behaviour depends on FWD (see Configuration).
- stall = (st_valid & full) | (ld_valid & !st_valid & hit & !FWD).
- Simultaneous enqueue and pop: count unchanged, both pointers advance.

## Timing
- Reset (asserted, async) forces:
  - state=IDLE, pointers=0, count=0, empty=1, mem_wreq=0, stall=0.
  - mem_waddr=0, mem_wdata=0 (head entry storage cleared); rdata=mem_rdata.
- Reset mid-drain discards all buffered stores. A pending mem_wreq drops without waiting for ack.
- Store-to-forward latency: a store enqueued at edge N is visible to loads from cycle N+1.
- Store-to-memory latency: mem_wreq rises in the cycle after edge N if the buffer was empty and IDLE.
- Each write is presented for ≥1 cycle; sustained throughput is one write per cycle while mem_wack is held high.
- stall is combinational from the current inputs and registered state. No handshake signal is registered twice.

## Configuration
- SB_FORWARD_EN defined: a load hit returns the data of the youngest matching entry (closest to tail). No stall is raised for loads.
- SB_FORWARD_EN undefined: a load hit asserts stall until every matching entry has popped; rdata=mem_rdata. No forwarding mux is built.

## Test plan
- Reset pulse low with 3 entries pending and mem_wreq=1 → immediately count=0, empty=1, mem_wreq=0; no further writes issued after release.
- Store 0x100←0xAAAA_0001 with mem_wack tied 0 → count=1; mem_wreq=1 next cycle with waddr=0x100, wdata=0xAAAA_0001; mem_wack pulse → count=0, FSM returns to IDLE.
- Five stores, DEPTH=4, mem_wack=0 → 5th store sees stall=1, count=4. Raise mem_wack for one cycle → 5th store enqueues the edge after the pop.
- Stores to 0x200 of 0x11 then 0x22, then a load 0x200 with mem_rdata=0xDEAD:
  - SB_FORWARD_EN defined → rdata=0x22, stall=0.
  - SB_FORWARD_EN undefined → stall=1 until both entries are acked, then rdata=0xDEAD.
- Load 0x300 with buffered stores only to 0x200 → rdata=mem_rdata, stall=0.
- mem_wack held 1, core storing every cycle → count stays at 1, one write per cycle, addresses emerge in issue order; pointer wrap past 2·DEPTH shows no corruption.
